// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller port bundle: hazard inputs from ID/EX/MEM and
// the write-enable / bubble / flush controls plus watchdog and counters.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freezes
// and a sticky memory watchdog. HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hif
);
  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int unsigned WCW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_timeout_q, mem_timeout_d;

  logic load_use, mem_stall;
  logic pc_write, ifid_write, idex_write, idex_bubble, ifid_flush;

  always_comb begin
    load_use  = hif.ex_memread & (hif.ex_rt != '0) & hif.id_valid &
                ((hif.ex_rt == hif.id_rs) | (hif.id_uses_rt & (hif.ex_rt == hif.id_rt)));
    mem_stall = hif.mem_req & ~hif.mem_ready;

    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (hif.branch_taken) begin
          idex_bubble = 1'b1;
          ifid_flush  = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Completion cycle releases the pipeline immediately; pending hazards wait one cycle.
        if (hif.mem_ready) begin
          state_d = RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
          if (wait_cnt_q == WAIT_LAST) mem_timeout_d = 1'b1;
          else                         wait_cnt_d    = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hif.pc_write    = pc_write;
  assign hif.ifid_write  = ifid_write;
  assign hif.idex_write  = idex_write;
  assign hif.idex_bubble = idex_bubble;
  assign hif.ifid_flush  = ifid_flush;
  assign hif.mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
`else
  assign hif.stall_cnt = '0;
  assign hif.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4, CNT_W=4; counter expectations
// follow HAZ_PERF_CNT_EN.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush}
  localparam logic [4:0] O_RESET  = 5'b00011;
  localparam logic [4:0] O_NORMAL = 5'b11100;
  localparam logic [4:0] O_LDUSE  = 5'b00110;
  localparam logic [4:0] O_BRANCH = 5'b11111;
  localparam logic [4:0] O_FREEZE = 5'b00000;

  hazard_ctrl_if #(.CNT_W(4)) hif ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {hif.pc_write, hif.ifid_write, hif.idex_write, hif.idex_bubble, hif.ifid_flush};
  endfunction

  function automatic logic [31:0] cnt(input int unsigned v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.id_valid     = 1'b0;
    hif.id_rs        = '0;
    hif.id_rt        = '0;
    hif.id_uses_rt   = 1'b0;
    hif.ex_memread   = 1'b0;
    hif.ex_rt        = '0;
    hif.branch_taken = 1'b0;
    hif.mem_req      = 1'b0;
    hif.mem_ready    = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rt);
    hif.ex_memread = 1'b1;
    hif.ex_rt      = rt;
    hif.id_rs      = rt;
    hif.id_valid   = 1'b1;
  endtask

  initial begin
    clear_inputs();
    #2;
    chk("reset_outs", 32'(outs()), 32'(O_RESET));
    chk("reset_timeout", 32'(hif.mem_timeout), 32'd0);
    chk("reset_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(hif.flush_cnt), 32'd0);

    @(negedge clk); rst = 1'b0; #1;
    chk("idle_outs", 32'(outs()), 32'(O_NORMAL));

    // Load-use: one bubble, then the load has left EX
    @(negedge clk); set_load_use(5'd8); #1;
    chk("load_use_outs", 32'(outs()), 32'(O_LDUSE));
    @(negedge clk); hif.ex_memread = 1'b0; #1;
    chk("after_load_use_outs", 32'(outs()), 32'(O_NORMAL));
    chk("stall_cnt_1", 32'(hif.stall_cnt), cnt(1));

    // $zero destination never stalls
    @(negedge clk); clear_inputs(); set_load_use(5'd0); #1;
    chk("zero_rt_outs", 32'(outs()), 32'(O_NORMAL));

    // rt match only matters when the ID instruction reads rt
    @(negedge clk); clear_inputs();
    hif.ex_memread = 1'b1; hif.ex_rt = 5'd9; hif.id_rt = 5'd9; hif.id_rs = 5'd1;
    hif.id_valid = 1'b1; hif.id_uses_rt = 1'b0; #1;
    chk("rt_unused_outs", 32'(outs()), 32'(O_NORMAL));
    @(negedge clk); hif.id_uses_rt = 1'b1; #1;
    chk("rt_used_outs", 32'(outs()), 32'(O_LDUSE));
    @(negedge clk); hif.id_valid = 1'b0; #1;
    chk("id_invalid_outs", 32'(outs()), 32'(O_NORMAL));
    chk("stall_cnt_2", 32'(hif.stall_cnt), cnt(2));

    // Branch overrides a simultaneous load-use
    @(negedge clk); clear_inputs(); set_load_use(5'd8); hif.branch_taken = 1'b1; #1;
    chk("branch_lu_outs", 32'(outs()), 32'(O_BRANCH));
    @(negedge clk); clear_inputs(); #1;
    chk("flush_cnt_1", 32'(hif.flush_cnt), cnt(1));
    chk("stall_cnt_still_2", 32'(hif.stall_cnt), cnt(2));

    // Memory stall of 3 cycles, branch held throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); hif.mem_req = 1'b1; hif.mem_ready = 1'b0; hif.branch_taken = 1'b1; #1;
      chk($sformatf("mem_freeze_%0d", i), 32'(outs()), 32'(O_FREEZE));
    end
    @(negedge clk); hif.mem_ready = 1'b1; #1;
    chk("mem_ready_outs", 32'(outs()), 32'(O_NORMAL));
    @(negedge clk); hif.mem_req = 1'b0; hif.mem_ready = 1'b0; #1;
    chk("post_mem_branch_outs", 32'(outs()), 32'(O_BRANCH));
    @(negedge clk); clear_inputs(); #1;
    chk("stall_cnt_5", 32'(hif.stall_cnt), cnt(5));
    chk("flush_cnt_2", 32'(hif.flush_cnt), cnt(2));
    chk("no_timeout_short_wait", 32'(hif.mem_timeout), 32'd0);

    // Watchdog: RUN entry cycle plus MEM_WAIT cycles 0..3, sets on the edge after the 4th
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); hif.mem_req = 1'b1; hif.mem_ready = 1'b0; #1;
      chk($sformatf("wd_outs_%0d", i), 32'(outs()), 32'(O_FREEZE));
      chk($sformatf("wd_timeout_%0d", i), 32'(hif.mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk); hif.mem_ready = 1'b1; #1;
    chk("wd_release_outs", 32'(outs()), 32'(O_NORMAL));
    @(negedge clk); clear_inputs(); #1;
    chk("wd_sticky", 32'(hif.mem_timeout), 32'd1);

    // Async reset in the middle of MEM_WAIT, away from any clock edge
    @(negedge clk); hif.mem_req = 1'b1; #1;
    chk("pre_abort_outs", 32'(outs()), 32'(O_FREEZE));
    @(negedge clk); #1;
    chk("in_wait_outs", 32'(outs()), 32'(O_FREEZE));
    #1 rst = 1'b1; #1;
    chk("async_rst_outs", 32'(outs()), 32'(O_RESET));
    chk("async_rst_timeout", 32'(hif.mem_timeout), 32'd0);
    chk("async_rst_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    @(negedge clk); rst = 1'b0; clear_inputs(); #1;
    chk("wait_aborted_outs", 32'(outs()), 32'(O_NORMAL));

    // Saturation: 20 consecutive load-use cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); set_load_use(5'd3); #1;
      chk($sformatf("sat_outs_%0d", i), 32'(outs()), 32'(O_LDUSE));
      chk($sformatf("sat_cnt_%0d", i), 32'(hif.stall_cnt), cnt((i > 15) ? 15 : i));
    end
    @(negedge clk); #1;
    chk("sat_final", 32'(hif.stall_cnt), cnt(15));
    #1 rst = 1'b1; #1;
    chk("sat_rst_outs", 32'(outs()), 32'(O_RESET));
    chk("sat_rst_cnt", 32'(hif.stall_cnt), 32'd0);
    @(negedge clk); rst = 1'b0; clear_inputs(); #1;
    chk("final_idle_outs", 32'(outs()), 32'(O_NORMAL));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
